// File: rtl/dbus_map_pkg.sv
// Address map, register offsets and reset constants
// shared by the data-bus target and its sub-blocks.
package dbus_map_pkg;

    localparam logic [3:0] REGION_RAM = 4'h0;
    localparam logic [3:0] REGION_IO  = 4'hF;

    localparam logic [1:0] IO_LED     = 2'd0;
    localparam logic [1:0] IO_CYCLES  = 2'd1;
    localparam logic [1:0] IO_COMPARE = 2'd2;
    localparam logic [1:0] IO_STATUS  = 2'd3;

    localparam logic [31:0] COMPARE_RST    = 32'hFFFF_FFFF;
    localparam int          STATUS_HIT_BIT = 0;

    typedef enum logic [1:0] {
        RGN_RAM  = 2'd0,
        RGN_IO   = 2'd1,
        RGN_NONE = 2'd2
    } region_e;

    function automatic region_e decode_region(input logic [3:0] top);
        region_e r;
        r = RGN_NONE;
        unique case (1'b1)
            (top == REGION_RAM): r = RGN_RAM;
            (top == REGION_IO):  r = RGN_IO;
            default:             r = RGN_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dbus_target_ram.sv
// Single-port synchronous-read RAM, read-first on a
// same-cycle write; contents are never reset.
module ram_sync #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dbus_target.sv
// Data-bus target: word RAM plus a small I/O block
// (LED, free-running cycle counter, compare/timer flag).
module dbus_target
    import dbus_map_pkg::*;
#(
    parameter int RAM_AW = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_data_w,
    input  logic        d_data_we,
    output logic [31:0] d_data_r,
    output logic [7:0]  led,
    output logic        timer_hit
);

    region_e     region;
    logic        ram_we;
    logic        io_we;
    logic [1:0]  io_sel;
    logic [31:0] ram_rdata;
    logic [31:0] rd_next;
    logic [31:0] rd_reg_q;
    logic        rd_ram_q;
    logic [7:0]  led_q;
    logic [31:0] cycles;
    logic [31:0] compare;
    logic        hit_set;
    logic        hit_clr;
    logic        unused_addr;

    assign unused_addr = ^{d_addr[27:RAM_AW+2], d_addr[1:0]};

    assign region = decode_region(d_addr[31:28]);
    assign io_sel = d_addr[3:2];
    assign ram_we = !reset && d_data_we && (region == RGN_RAM);
    assign io_we  = d_data_we && (region == RGN_IO);

    ram_sync #(
        .AW(RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (d_addr[RAM_AW+1:2]),
        .wdata (d_data_w),
        .rdata (ram_rdata)
    );

    always_comb begin
        rd_next = '0;
        if (region == RGN_IO) begin
            unique case (io_sel)
                IO_LED:     rd_next = {24'h0, led_q};
                IO_CYCLES:  rd_next = cycles;
                IO_COMPARE: rd_next = compare;
                IO_STATUS:  rd_next[STATUS_HIT_BIT] = timer_hit;
                default:    rd_next = '0;
            endcase
        end
    end

    // The RAM already registers its read word, so the load
    // register keeps only a RAM-select bit for that path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_reg_q <= '0;
            rd_ram_q <= 1'b0;
        end else begin
            rd_reg_q <= rd_next;
            rd_ram_q <= (region == RGN_RAM);
        end
    end

    assign d_data_r = rd_ram_q ? ram_rdata : rd_reg_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q   <= '0;
            compare <= COMPARE_RST;
        end else if (io_we) begin
            if (io_sel == IO_LED) begin
                led_q <= d_data_w[7:0];
            end
            if (io_sel == IO_COMPARE) begin
                compare <= d_data_w;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles <= '0;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end

    assign hit_set = (cycles == compare);
    assign hit_clr = io_we && (io_sel == IO_STATUS)
                     && d_data_w[STATUS_HIT_BIT];

    // A match in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_hit <= 1'b0;
        end else begin
            timer_hit <= hit_set | (timer_hit & ~hit_clr);
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_dbus_target.sv
// Directed bench for dbus_target: RAM, I/O registers,
// timer flag and asynchronous reset behaviour.
module tb_dbus_target;

    logic        clk;
    logic        reset;
    logic [31:0] d_addr;
    logic [31:0] d_data_w;
    logic        d_data_we;
    logic [31:0] d_data_r;
    logic [7:0]  led;
    logic        timer_hit;

    int          errors;
    int          checks;
    int unsigned cyc;

    dbus_target #(
        .RAM_AW(10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .d_addr    (d_addr),
        .d_data_w  (d_data_w),
        .d_data_we (d_data_we),
        .d_data_r  (d_data_r),
        .led       (led),
        .timer_hit (timer_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        if (reset) cyc = 0;
        else cyc = cyc + 1;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] w,
                         input logic we);
        d_addr    = a;
        d_data_w  = w;
        d_data_we = we;
    endtask

    initial begin
        int          guard;
        int unsigned target;
        logic [31:0] exp;

        errors = 0;
        checks = 0;
        cyc    = 0;
        reset  = 1'b1;
        issue(32'h0, 32'h0, 1'b0);
        #1;
        chk("rst_data", d_data_r, 32'h0);
        chk("rst_led", {24'h0, led}, 32'h0);
        chk("rst_hit", {31'h0, timer_hit}, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // COMPARE=20 right after reset
        issue(32'hF000_0008, 32'd20, 1'b1);
        tick();
        issue(32'h0, 32'h0, 1'b0);
        guard = 0;
        while (cyc < 20 && guard < 100) begin
            tick();
            guard++;
        end
        chk("hit_before", {31'h0, timer_hit}, 32'h0);
        tick();
        chk("hit_set", {31'h0, timer_hit}, 32'h1);

        issue(32'hF000_000C, 32'h0, 1'b0);
        tick();
        chk("status_rd", d_data_r, 32'h1);

        issue(32'hF000_000C, 32'h1, 1'b1);
        tick();
        chk("hit_clr", {31'h0, timer_hit}, 32'h0);

        // clear collides with a new match
        target = cyc + 4;
        issue(32'hF000_0008, target, 1'b1);
        tick();
        issue(32'h0, 32'h0, 1'b0);
        guard = 0;
        while (cyc != target && guard < 100) begin
            tick();
            guard++;
        end
        chk("coll_wait", cyc, target);
        issue(32'hF000_000C, 32'h1, 1'b1);
        tick();
        chk("coll_hit", {31'h0, timer_hit}, 32'h1);

        issue(32'hF000_0008, 32'h0, 1'b0);
        tick();
        chk("cmp_rd", d_data_r, target);

        // RAM store/load and aliasing
        issue(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        tick();
        issue(32'h0000_0010, 32'h0, 1'b0);
        tick();
        chk("ram_ld", d_data_r, 32'hDEAD_BEEF);
        issue(32'h0000_1010, 32'h0, 1'b0);
        tick();
        chk("ram_alias", d_data_r, 32'hDEAD_BEEF);
        issue(32'h0FFF_F013, 32'h0, 1'b0);
        tick();
        chk("ram_alias_lo", d_data_r, 32'hDEAD_BEEF);

        // read-first
        issue(32'h0000_0010, 32'h1111_1111, 1'b1);
        tick();
        issue(32'h0000_0010, 32'h2222_2222, 1'b1);
        tick();
        chk("rf_old", d_data_r, 32'h1111_1111);
        issue(32'h0000_0010, 32'h0, 1'b0);
        tick();
        chk("rf_new", d_data_r, 32'h2222_2222);

        // LED
        issue(32'hF000_0000, 32'h0000_01A5, 1'b1);
        tick();
        chk("led_out", {24'h0, led}, 32'h0000_00A5);
        issue(32'hF000_0000, 32'h0, 1'b0);
        tick();
        chk("led_rd", d_data_r, 32'h0000_00A5);
        issue(32'hF123_4560, 32'h0, 1'b0);
        tick();
        chk("led_alias", d_data_r, 32'h0000_00A5);

        // unmapped
        issue(32'h5000_0010, 32'h1234_5678, 1'b1);
        tick();
        issue(32'h5000_0010, 32'h0, 1'b0);
        tick();
        chk("unmap_rd", d_data_r, 32'h0);
        issue(32'h0000_0010, 32'h0, 1'b0);
        tick();
        chk("unmap_ram", d_data_r, 32'h2222_2222);

        // CYCLES is read-only
        issue(32'hF000_0004, 32'h0, 1'b1);
        tick();
        issue(32'hF000_0004, 32'h0, 1'b0);
        exp = cyc;
        tick();
        chk("cyc_rd", d_data_r, exp);
        chk("hit_hold", {31'h0, timer_hit}, 32'h1);

        // asynchronous reset between edges
        issue(32'h0000_0010, 32'h0, 1'b0);
        tick();
        chk("pre_rst_ld", d_data_r, 32'h2222_2222);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_data", d_data_r, 32'h0);
        chk("arst_led", {24'h0, led}, 32'h0);
        chk("arst_hit", {31'h0, timer_hit}, 32'h0);
        issue(32'h0000_0010, 32'h0000_0BAD, 1'b1);
        tick();
        chk("rst_hold", d_data_r, 32'h0);
        reset = 1'b0;
        issue(32'h0000_0000, 32'h0, 1'b0);
        tick();
        tick();
        chk("rel_cnt", cyc, 32'd2);
        issue(32'hF000_0004, 32'h0, 1'b0);
        tick();
        chk("rel_cyc", d_data_r, 32'd2);
        issue(32'h0000_0010, 32'h0, 1'b0);
        tick();
        chk("ram_keep", d_data_r, 32'h2222_2222);
        issue(32'hF000_0008, 32'h0, 1'b0);
        tick();
        chk("cmp_rst", d_data_r, 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
